saida_bcd_sequencial: RTL and testbench
=======================================

Name: saida_bcd_sequencial

Overview:
- Downstream output stage of the CPU OUT path. Accepts one 32-bit data word per handshake.
- Converts the word to three BCD digits (unidade/dezena/centena) with an iterative shift-add-3 (double-dabble) datapath.
- Holds the digits for the existing seven-segment decoders.
- Replaces the combinational binary-to-BCD path, so conversion is multi-cycle and never combinational in the CPU clock domain.

Parameters:
- DATA_W, 32, width of the incoming data word.
- CONV_BITS, 10, low-order bits fed to the shift-add-3 loop; 2^10 > 999.
- MAX_VAL, 999, largest displayable value; anything above saturates.

Ports:
- clock  input  1  single system clock, all state on posedge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- dado_in  input  DATA_W  binary word from the CPU OUT path.
- in_valid  input  1  dado_in valid.
- in_ready  output  1  block idle and able to accept a word.
- unidade  output  4  BCD units digit.
- dezena  output  4  BCD tens digit.
- centena  output  4  BCD hundreds digit.
- overflow  output  1  last accepted word exceeded MAX_VAL.
- out_valid  output  1  one-cycle pulse when the digit outputs have updated.
- ocupado  output  1  conversion in progress (mirror of state == CONV).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; unidade=dezena=centena=0; overflow=0; out_valid=0; ocupado=0; in_ready=1.
  - Iteration counter and shift register cleared.
  - Asserting reset mid-conversion aborts the conversion; no out_valid is produced for the aborted word.
- State machine: IDLE, CONV, SAT.
- IDLE:
  - in_ready=1.
  - On the posedge where in_valid=1, the word is captured (edge E0).
  - If dado_in > MAX_VAL (full DATA_W unsigned compare) → SAT.
  - Otherwise, load dado_in[CONV_BITS-1:0] into the shift register with a zeroed 12-bit BCD field, set counter=0 → CONV.
- CONV:
  - in_ready=0, ocupado=1; in_valid is ignored.
  - Each edge performs one step: add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1.
  - After CONV_BITS steps (edges E1..E10), the digits are registered to the outputs at E10, overflow=0, out_valid=1 for the following cycle, state → IDLE.
  - in_ready=1 from the cycle after E10.
  - Latency: CONV_BITS cycles from accept to out_valid.
- SAT:
  - At edge E1: unidade=dezena=centena=9, overflow=1, out_valid=1 for one cycle, state → IDLE.
  - Latency: 1 cycle.
- Outputs hold their last value until the next completed conversion. A new accept does not disturb the displayed digits until the result lands.
- out_valid is never high for two consecutive cycles, and is never high while in_ready=0.
- Back-to-back: in_valid held high → the next word is accepted on the first edge where in_ready=1. Throughput is one word per CONV_BITS+1 cycles.
- Boundary values:
  - dado_in=0 → digits 0,0,0 after the full CONV_BITS cycles (no short-cut).
  - dado_in=999 → 9,9,9 with overflow=0.
  - dado_in=1000 → saturate, overflow=1.

Optional Feature:
- Macro: SAIDA_BCD_BLANK_EN.
- Defined:
  - Leading-zero digits are driven to the package BLANK code (4'hF), which the display decoder maps to all segments off.
  - centena is blanked if 0; dezena is blanked if both it and centena are 0.
  - unidade is never blanked.
  - Saturation output is unaffected.
- Undefined: leading zeros are shown as 0; the BLANK code is never produced.

Decomposition:
- Package saida_bcd_pkg holds:
  - state typedef (IDLE, CONV, SAT);
  - BLANK=4'hF;
  - SAT_DIGIT=4'd9;
  - default MAX_VAL, CONV_BITS.
- One sub-module, bcd_ajuste_digito: purely combinational 4-bit "if ≥5 add 3" corrector, instantiated three times inside the CONV step.
- Counter, FSM and output registers stay in the top.

Test Plan:
- Reset release, no input → in_ready=1, digits 0,0,0, overflow=0, out_valid never asserted.
- dado_in=573, in_valid one cycle → ocupado for 10 cycles, then out_valid pulse with centena=5, dezena=7, unidade=3, overflow=0.
- dado_in=32'd1000, then 32'hFFFF_FFFF → each gives out_valid after 1 cycle with 9,9,9, overflow=1.
- dado_in=7, then 42 with in_valid held high → second accept exactly 11 cycles after the first; outputs 0,0,7 then 0,4,2. With SAIDA_BCD_BLANK_EN: F,F,7 then F,4,2.
- Accept 999, assert reset low at cycle 5 of CONV → outputs 0,0,0 immediately, no out_valid; after release, in_ready=1 and a new word 100 converts to 1,0,0.
- in_valid pulsed while ocupado=1 → word ignored, digits from the earlier conversion unaffected.

Source files
------------

// File: rtl/saida_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD output stage.
// Holds the FSM state encoding, display codes and default sizing.
package saida_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SAT  = 2'd2
  } estado_t;

  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [3:0] SAT_DIGIT = 4'd9;

  localparam int MAX_VAL_DEF   = 999;
  localparam int CONV_BITS_DEF = 10;
  localparam int BCD_W         = 12;

endpackage

// File: rtl/saida_bcd_sequencial_if.sv
// Word-in / digits-out bundle between the CPU OUT path and the BCD output stage.
// master = CPU side (drives the word), slave = conversion block.
interface saida_bcd_sequencial_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] dado_in;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        unidade;
  logic [3:0]        dezena;
  logic [3:0]        centena;
  logic              overflow;
  logic              out_valid;
  logic              ocupado;

  modport master (
    output dado_in, in_valid,
    input  in_ready, unidade, dezena, centena, overflow, out_valid, ocupado
  );

  modport slave (
    input  dado_in, in_valid,
    output in_ready, unidade, dezena, centena, overflow, out_valid, ocupado
  );
endinterface

// File: rtl/bcd_ajuste_digito.sv
// Combinational double-dabble nibble corrector: adds 3 when the digit is 5 or more.
// Zero latency, no flow control.
module bcd_ajuste_digito (
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/saida_bcd_sequencial.sv
// Iterative binary-to-BCD output stage: CONV_BITS cycles per word (1 when saturating), in_ready low while busy.
// Optional SAIDA_BCD_BLANK_EN blanks leading-zero digits with the BLANK code.
module saida_bcd_sequencial
  import saida_bcd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CONV_BITS = CONV_BITS_DEF,
  parameter int MAX_VAL   = MAX_VAL_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  saida_bcd_sequencial_if.slave bus
);

  localparam int SR_W  = BCD_W + CONV_BITS;
  localparam int CNT_W = $clog2(CONV_BITS + 1);

  estado_t           r_estado, w_estado_nxt;
  logic [SR_W-1:0]   r_sr, w_sr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]        r_uni, r_dez, r_cen;
  logic [3:0]        w_uni_nxt, w_dez_nxt, w_cen_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_out_vld, w_out_vld_nxt;

  logic [BCD_W-1:0]  w_adj;
  logic [SR_W-1:0]   w_passo;
  logic [3:0]        w_uni_fin, w_dez_fin, w_cen_fin;
  logic [3:0]        w_dez_disp, w_cen_disp;

  bcd_ajuste_digito u_adj_uni (.i_dig(r_sr[CONV_BITS     +: 4]), .o_dig(w_adj[3:0]));
  bcd_ajuste_digito u_adj_dez (.i_dig(r_sr[CONV_BITS + 4 +: 4]), .o_dig(w_adj[7:4]));
  bcd_ajuste_digito u_adj_cen (.i_dig(r_sr[CONV_BITS + 8 +: 4]), .o_dig(w_adj[11:8]));

  // One double-dabble step: correct every nibble, then shift {bcd, bin} left.
  assign w_passo   = {w_adj, r_sr[CONV_BITS-1:0]} << 1;
  assign w_uni_fin = w_passo[CONV_BITS     +: 4];
  assign w_dez_fin = w_passo[CONV_BITS + 4 +: 4];
  assign w_cen_fin = w_passo[CONV_BITS + 8 +: 4];

`ifdef SAIDA_BCD_BLANK_EN
  assign w_cen_disp = (w_cen_fin == 4'd0) ? BLANK : w_cen_fin;
  assign w_dez_disp = ((w_cen_fin == 4'd0) && (w_dez_fin == 4'd0)) ? BLANK : w_dez_fin;
`else
  assign w_cen_disp = w_cen_fin;
  assign w_dez_disp = w_dez_fin;
`endif

  always_comb begin
    w_estado_nxt  = r_estado;
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_uni_nxt     = r_uni;
    w_dez_nxt     = r_dez;
    w_cen_nxt     = r_cen;
    w_ovf_nxt     = r_ovf;
    w_out_vld_nxt = 1'b0;

    case (r_estado)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.dado_in > DATA_W'(MAX_VAL)) begin
            w_estado_nxt = SAT;
          end else begin
            w_sr_nxt     = SR_W'(bus.dado_in[CONV_BITS-1:0]);
            w_cnt_nxt    = '0;
            w_estado_nxt = CONV;
          end
        end
      end
      CONV: begin
        w_sr_nxt  = w_passo;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(CONV_BITS - 1)) begin
          w_uni_nxt     = w_uni_fin;
          w_dez_nxt     = w_dez_disp;
          w_cen_nxt     = w_cen_disp;
          w_ovf_nxt     = 1'b0;
          w_out_vld_nxt = 1'b1;
          w_estado_nxt  = IDLE;
        end
      end
      SAT: begin
        w_uni_nxt     = SAT_DIGIT;
        w_dez_nxt     = SAT_DIGIT;
        w_cen_nxt     = SAT_DIGIT;
        w_ovf_nxt     = 1'b1;
        w_out_vld_nxt = 1'b1;
        w_estado_nxt  = IDLE;
      end
      default: begin
        w_estado_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_uni     <= '0;
      r_dez     <= '0;
      r_cen     <= '0;
      r_ovf     <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_estado  <= w_estado_nxt;
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_uni     <= w_uni_nxt;
      r_dez     <= w_dez_nxt;
      r_cen     <= w_cen_nxt;
      r_ovf     <= w_ovf_nxt;
      r_out_vld <= w_out_vld_nxt;
    end
  end

  assign bus.in_ready  = (r_estado == IDLE);
  assign bus.ocupado   = (r_estado == CONV);
  assign bus.unidade   = r_uni;
  assign bus.dezena    = r_dez;
  assign bus.centena   = r_cen;
  assign bus.overflow  = r_ovf;
  assign bus.out_valid = r_out_vld;

endmodule

// File: tb/tb_saida_bcd_sequencial.sv
// Bench for saida_bcd_sequencial: directed boundary cases plus random words against a decimal-arithmetic model.
module tb_saida_bcd_sequencial;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  saida_bcd_sequencial_if bus ();

  saida_bcd_sequencial dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] disp();
    return {bus.centena, bus.dezena, bus.unidade};
  endfunction

  // Decimal digits from plain division; leading-zero blanking when enabled.
  function automatic logic [11:0] model(input logic [31:0] v);
    logic [3:0] c, d, u;
    if (v > 32'd999) return {4'd9, 4'd9, 4'd9};
    c = 4'(v / 100);
    d = 4'((v / 10) % 10);
    u = 4'(v % 10);
`ifdef SAIDA_BCD_BLANK_EN
    if (c == 4'd0) begin
      c = 4'hF;
      if (d == 4'd0) d = 4'hF;
    end
`endif
    return {c, d, u};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready_before_send", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] v);
    int lat, ocu;
    logic [11:0] prev;
    wait_ready();
    prev = disp();
    bus.dado_in  = v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (v <= 32'd999) chk("hold_during_conv", 32'(disp()), 32'(prev));
    lat = 0;
    ocu = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.ocupado) ocu++;
      tick();
      lat++;
    end
    chk("latency", lat, (v > 32'd999) ? 32'd1 : 32'd10);
    chk("ocupado_cycles", ocu, (v > 32'd999) ? 32'd0 : 32'd10);
    chk("digits", 32'(disp()), 32'(model(v)));
    chk("overflow", 32'(bus.overflow), (v > 32'd999) ? 32'd1 : 32'd0);
    chk("ready_with_valid", 32'(bus.in_ready), 32'd1);
    tick();
    chk("valid_single_pulse", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int cnt, lat, nv, sel;
    logic [31:0] v;
    n_vec = 0;
    n_err = 0;
    bus.dado_in  = '0;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_digits", 32'(disp()), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) nv++;
    end
    chk("idle_no_valid", nv, 32'd0);
    chk("idle_ready", 32'(bus.in_ready), 32'd1);

    send(32'd573);
    send(32'd1000);
    send(32'hFFFF_FFFF);

    // Back-to-back with in_valid held high.
    wait_ready();
    bus.dado_in  = 32'd7;
    bus.in_valid = 1'b1;
    tick();
    bus.dado_in = 32'd42;
    cnt = 0;
    while (!bus.in_ready && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("b2b_first_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_first_digits", 32'(disp()), 32'(model(32'd7)));
    tick();
    cnt++;
    bus.in_valid = 1'b0;
    chk("b2b_accept_gap", cnt, 32'd11);
    chk("b2b_second_busy", 32'(bus.ocupado), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("b2b_second_latency", lat, 32'd10);
    chk("b2b_second_digits", 32'(disp()), 32'(model(32'd42)));
    tick();

    // Reset in the middle of a conversion.
    wait_ready();
    bus.dado_in  = 32'd999;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    #1;
    chk("abort_digits", 32'(disp()), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_ocupado", 32'(bus.ocupado), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) nv++;
    end
    chk("abort_no_valid", nv, 32'd0);
    send(32'd100);

    // in_valid pulsed while busy must be ignored.
    wait_ready();
    bus.dado_in  = 32'd573;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.dado_in  = 32'd5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 3;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("ignore_latency", lat, 32'd10);
    chk("ignore_digits", 32'(disp()), 32'(model(32'd573)));
    nv = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.out_valid) nv++;
    end
    chk("ignore_no_extra_valid", nv, 32'd0);
    chk("ignore_digits_kept", 32'(disp()), 32'(model(32'd573)));

    send(32'd0);
    send(32'd999);
    send(32'd9);
    send(32'd10);
    send(32'd99);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = 32'($urandom_range(0, 999));
        1:       v = 32'($urandom_range(0, 99));
        2:       v = 32'($urandom_range(1000, 5000));
        default: v = $urandom;
      endcase
      send(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
